// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage RV32I core.
//
// Tracks the destination registers of the instructions sitting in ID/EX
// and EX/MEM. From them it generates same-cycle stall / flush / bubble /
// freeze controls and registered EX operand-forwarding selects.
//
// Build option: define FORWARD_EN to enable EX/MEM and WB bypassing.
// Without it, every RAW dependence on EX or MEM stalls and fwd_a/fwd_b
// stay 00.
//
// Parameters:
//   RA_W          register address width
//   CNT_W         width of the saturating stall-cycle counter
// Ports:
//   clk, rstn     rising-edge clock, asynchronous active-low reset
//   id_*          decoded flags of the instruction currently in ID
//   ex_redirect   EX resolved a taken branch / jal / jalr
//   mem_ready     data memory completes its access this cycle
//   stall_if      hold PC and IF/ID
//   flush_id      replace IF/ID with a NOP
//   bubble_ex     load a NOP into ID/EX
//   freeze        hold every pipeline register
//   fwd_a, fwd_b  EX operand select: 00 regfile, 01 EX/MEM, 10 WB data
//   stall_cycles  saturating count of stall_if | freeze cycles
//
// The register file is write-first, so an instruction in WB can never
// cause a hazard. Nothing reads a WB entry or a load flag in MEM, so
// neither is kept in the scoreboard.
module hazard_ctrl #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_regwrite,
   input  logic             id_load,
   input  logic             id_memop,
   input  logic             ex_redirect,
   input  logic             mem_ready,
   output logic             stall_if,
   output logic             flush_id,
   output logic             bubble_ex,
   output logic             freeze,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [RA_W-1:0]  REG_ZERO  = {RA_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]       FWD_RF    = 2'b00;
   localparam logic [1:0]       FWD_EXMEM = 2'b01;
   localparam logic [1:0]       FWD_WB    = 2'b10;

   // scoreboard: EX entry (mirrors ID/EX)
   logic            ex_valid_q, ex_valid_d;
   logic [RA_W-1:0] ex_rd_q, ex_rd_d;
   logic            ex_regwrite_q, ex_regwrite_d;
   logic            ex_load_q, ex_load_d;
   logic            ex_memop_q, ex_memop_d;
   // scoreboard: MEM entry (mirrors EX/MEM)
   logic            mem_valid_q, mem_valid_d;
   logic [RA_W-1:0] mem_rd_q, mem_rd_d;
   logic            mem_regwrite_q, mem_regwrite_d;
   logic            mem_memop_q, mem_memop_d;
   // forwarding selects and performance counter
   logic [1:0]       fwd_a_q, fwd_a_d;
   logic [1:0]       fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic match_ex_a, match_ex_b, match_mem_a, match_mem_b;
   logic ex_dep, mem_dep, data_stall;

   // RAW match of one source operand against one scoreboard entry; x0 never matches
   function automatic logic src_match(
      input logic            valid,
      input logic            regwrite,
      input logic [RA_W-1:0] rd,
      input logic [RA_W-1:0] rs,
      input logic            use_src
   );
      src_match = valid & regwrite & (rd == rs) & (rs != REG_ZERO) & use_src;
   endfunction

   // Bypass source for one operand; the younger producer (EX) has priority
   function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem);
      if (m_ex) begin
         fwd_sel = FWD_EXMEM;
      end else if (m_mem) begin
         fwd_sel = FWD_WB;
      end else begin
         fwd_sel = FWD_RF;
      end
   endfunction

   assign match_ex_a  = src_match(ex_valid_q, ex_regwrite_q, ex_rd_q, id_rs1, id_use_rs1);
   assign match_ex_b  = src_match(ex_valid_q, ex_regwrite_q, ex_rd_q, id_rs2, id_use_rs2);
   assign match_mem_a = src_match(mem_valid_q, mem_regwrite_q, mem_rd_q, id_rs1, id_use_rs1);
   assign match_mem_b = src_match(mem_valid_q, mem_regwrite_q, mem_rd_q, id_rs2, id_use_rs2);
   assign ex_dep      = match_ex_a | match_ex_b;
   assign mem_dep     = match_mem_a | match_mem_b;

   // A memory access in MEM that has not completed stalls the whole pipe
   assign freeze = mem_valid_q & mem_memop_q & ~mem_ready;

   // Data-hazard detection for the ID instruction
   always_comb begin
      data_stall = 1'b0;
`ifdef FORWARD_EN
      // ALU results bypass; only a load in EX has no data yet
      data_stall = id_valid & ex_dep & ex_load_q;
`else
      // no bypass: load or ALU producer in EX, or any producer in MEM, stalls
      data_stall = id_valid & ((ex_dep & ex_load_q) | (ex_dep & ~ex_load_q) | mem_dep);
`endif
   end

   // Pipeline controls, priority freeze > redirect > data stall
   always_comb begin
      stall_if  = 1'b0;
      flush_id  = 1'b0;
      bubble_ex = 1'b0;
      if (freeze) begin
         // a pending redirect waits in EX until the memory access completes
         stall_if  = 1'b0;
         flush_id  = 1'b0;
         bubble_ex = 1'b0;
      end else if (ex_redirect) begin
         // ID holds a wrong-path instruction: kill it instead of stalling
         flush_id  = 1'b1;
         bubble_ex = 1'b1;
      end else if (data_stall) begin
         stall_if  = 1'b1;
         bubble_ex = 1'b1;
      end else begin
         stall_if  = 1'b0;
         flush_id  = 1'b0;
         bubble_ex = 1'b0;
      end
   end

   // Scoreboard shift, forwarding select and counter next-state
   always_comb begin
      ex_valid_d     = ex_valid_q;
      ex_rd_d        = ex_rd_q;
      ex_regwrite_d  = ex_regwrite_q;
      ex_load_d      = ex_load_q;
      ex_memop_d     = ex_memop_q;
      mem_valid_d    = mem_valid_q;
      mem_rd_d       = mem_rd_q;
      mem_regwrite_d = mem_regwrite_q;
      mem_memop_d    = mem_memop_q;
      fwd_a_d        = fwd_a_q;
      fwd_b_d        = fwd_b_q;
      if (!freeze) begin
         ex_valid_d     = id_valid & ~bubble_ex;
         ex_rd_d        = id_rd;
         ex_regwrite_d  = id_regwrite;
         ex_load_d      = id_load;
         ex_memop_d     = id_memop;
         mem_valid_d    = ex_valid_q;
         mem_rd_d       = ex_rd_q;
         mem_regwrite_d = ex_regwrite_q;
         mem_memop_d    = ex_memop_q;
`ifdef FORWARD_EN
         if (id_valid && !bubble_ex) begin
            fwd_a_d = fwd_sel(match_ex_a, match_mem_a);
            fwd_b_d = fwd_sel(match_ex_b, match_mem_b);
         end else begin
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
         end
`else
         fwd_a_d = FWD_RF;
         fwd_b_d = FWD_RF;
`endif
      end else begin
         // frozen: every entry and both selects keep their value
         fwd_a_d = fwd_a_q;
         fwd_b_d = fwd_b_q;
      end

      if ((stall_if || freeze) && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_valid_q     <= 1'b0;
         ex_rd_q        <= REG_ZERO;
         ex_regwrite_q  <= 1'b0;
         ex_load_q      <= 1'b0;
         ex_memop_q     <= 1'b0;
         mem_valid_q    <= 1'b0;
         mem_rd_q       <= REG_ZERO;
         mem_regwrite_q <= 1'b0;
         mem_memop_q    <= 1'b0;
         fwd_a_q        <= FWD_RF;
         fwd_b_q        <= FWD_RF;
         cnt_q          <= {CNT_W{1'b0}};
      end else begin
         ex_valid_q     <= ex_valid_d;
         ex_rd_q        <= ex_rd_d;
         ex_regwrite_q  <= ex_regwrite_d;
         ex_load_q      <= ex_load_d;
         ex_memop_q     <= ex_memop_d;
         mem_valid_q    <= mem_valid_d;
         mem_rd_q       <= mem_rd_d;
         mem_regwrite_q <= mem_regwrite_d;
         mem_memop_q    <= mem_memop_d;
         fwd_a_q        <= fwd_a_d;
         fwd_b_q        <= fwd_b_d;
         cnt_q          <= cnt_d;
      end
   end

   assign fwd_a        = fwd_a_q;
   assign fwd_b        = fwd_b_q;
   assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand-written
// freeze/redirect/reset sequences, then random stimulus against an
// instruction-level pipeline model. A second instance with a 2-bit
// counter exercises counter saturation.
`timescale 1ns/1ps
module tb_hazard_ctrl;

   localparam int RA_W  = 5;
   localparam int CNT_W = 16;
   localparam int SAT_W = 2;
`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rstn;
   logic             id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_load, id_memop;
   logic [RA_W-1:0]  id_rs1, id_rs2, id_rd;
   logic             ex_redirect, mem_ready;
   logic             stall_if, flush_id, bubble_ex, freeze;
   logic [1:0]       fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cycles;
   logic             s_stall_if, s_flush_id, s_bubble_ex, s_freeze;
   logic [1:0]       s_fwd_a, s_fwd_b;
   logic [SAT_W-1:0] s_stall_cycles;

   hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_load(id_load), .id_memop(id_memop),
      .ex_redirect(ex_redirect), .mem_ready(mem_ready), .stall_if(stall_if),
      .flush_id(flush_id), .bubble_ex(bubble_ex), .freeze(freeze), .fwd_a(fwd_a),
      .fwd_b(fwd_b), .stall_cycles(stall_cycles));

   hazard_ctrl #(.RA_W(RA_W), .CNT_W(SAT_W)) dut_sat (
      .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_load(id_load), .id_memop(id_memop),
      .ex_redirect(ex_redirect), .mem_ready(mem_ready), .stall_if(s_stall_if),
      .flush_id(s_flush_id), .bubble_ex(s_bubble_ex), .freeze(s_freeze), .fwd_a(s_fwd_a),
      .fwd_b(s_fwd_b), .stall_cycles(s_stall_cycles));

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       ld;
      logic       mop;
   } instr_t;

   // one table record: inputs plus expected {stall,flush,bubble,freeze,fwd_a,fwd_b}
   typedef struct {
      instr_t     ins;
      logic       redir;
      logic       mrdy;
      logic [7:0] exp;
   } vec_t;

   int n_pass  = 0;
   int n_total = 0;

   // model: instructions past ID, index 0 = EX, 1 = MEM, 2 = WB
   instr_t pipe [3];
   logic [1:0] m_fa, m_fb;
   int m_cnt, m_cnt_s;
   logic e_stall, e_flush, e_bubble, e_freeze;

   function automatic instr_t nop();
      instr_t i;
      i.v = 1'b0; i.rs1 = 5'd0; i.rs2 = 5'd0; i.u1 = 1'b0; i.u2 = 1'b0;
      i.rd = 5'd0; i.rw = 1'b0; i.ld = 1'b0; i.mop = 1'b0;
      return i;
   endfunction

   function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      instr_t i;
      i = nop();
      i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = 1'b1; i.u2 = 1'b1; i.rw = 1'b1;
      return i;
   endfunction

   function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] rs1);
      instr_t i;
      i = nop();
      i.v = 1'b1; i.rd = rd; i.rs1 = rs1; i.u1 = 1'b1; i.rw = 1'b1; i.ld = 1'b1; i.mop = 1'b1;
      return i;
   endfunction

   function automatic logic [7:0] e(input logic st, input logic fl, input logic bu, input logic fr,
                                    input logic [1:0] fa, input logic [1:0] fb);
      return {st, fl, bu, fr, fa, fb};
   endfunction

   function automatic vec_t row(input instr_t ins, input logic [7:0] exp);
      vec_t r;
      r.ins = ins; r.redir = 1'b0; r.mrdy = 1'b1; r.exp = exp;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic set_in(input instr_t ins, input logic redir, input logic mrdy);
      id_valid = ins.v; id_rs1 = ins.rs1; id_rs2 = ins.rs2; id_use_rs1 = ins.u1;
      id_use_rs2 = ins.u2; id_rd = ins.rd; id_regwrite = ins.rw; id_load = ins.ld;
      id_memop = ins.mop; ex_redirect = redir; mem_ready = mrdy;
   endtask

   task automatic apply(input instr_t ins, input logic redir, input logic mrdy);
      @(negedge clk);
      set_in(ins, redir, mrdy);
      #1;
   endtask

   function automatic logic [7:0] outs();
      return {stall_if, flush_id, bubble_ex, freeze, fwd_a, fwd_b};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      set_in(nop(), 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) pipe[k] = nop();
      m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0; m_cnt_s = 0;
      #1;
      chk("reset_outs", 32'(outs()), 32'd0);
      chk("reset_cnt", 32'(stall_cycles), 32'd0);
   endtask

   // ---------------- reference model ----------------
   function automatic logic reads(input instr_t p, input logic [4:0] rs, input logic u);
      return p.v && p.rw && (p.rd == rs) && (rs != 5'd0) && u;
   endfunction

   function automatic logic [1:0] src_of(input logic [4:0] rs, input logic u);
      if (reads(pipe[0], rs, u)) return 2'b01;
      else if (reads(pipe[1], rs, u)) return 2'b10;
      else return 2'b00;
   endfunction

   task automatic model_eval();
      logic dep_ex, dep_mem, hazard;
      dep_ex   = reads(pipe[0], id_rs1, id_use_rs1) || reads(pipe[0], id_rs2, id_use_rs2);
      dep_mem  = reads(pipe[1], id_rs1, id_use_rs1) || reads(pipe[1], id_rs2, id_use_rs2);
      hazard   = id_valid && (FWD ? (dep_ex && pipe[0].ld) : (dep_ex || dep_mem));
      e_freeze = pipe[1].v && pipe[1].mop && !mem_ready;
      e_flush  = !e_freeze && ex_redirect;
      e_bubble = !e_freeze && (ex_redirect || hazard);
      e_stall  = !e_freeze && !ex_redirect && hazard;
   endtask

   task automatic model_step();
      instr_t ins;
      logic   enters;
      if (!e_freeze) begin
         enters = id_valid && !e_bubble;
         m_fa = (FWD && enters) ? src_of(id_rs1, id_use_rs1) : 2'b00;
         m_fb = (FWD && enters) ? src_of(id_rs2, id_use_rs2) : 2'b00;
         ins = nop();
         if (enters) begin
            ins.v = 1'b1; ins.rd = id_rd; ins.rw = id_regwrite; ins.ld = id_load; ins.mop = id_memop;
         end
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = ins;
      end
      if (e_stall || e_freeze) begin
         if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
         if (m_cnt_s < (1 << SAT_W) - 1) m_cnt_s++;
      end
   endtask

   function automatic instr_t rand_instr();
      instr_t i;
      int kind;
      i = nop();
      i.v   = ($urandom_range(0, 7) != 0);
      i.rs1 = 5'($urandom_range(0, 3));
      i.rs2 = 5'($urandom_range(0, 3));
      i.rd  = 5'($urandom_range(0, 3));
      i.u1  = ($urandom_range(0, 4) != 0);
      i.u2  = ($urandom_range(0, 1) != 0);
      kind  = int'($urandom_range(0, 3));
      case (kind)
         0: begin i.rw = 1'b1; end
         1: begin i.rw = 1'b1; i.ld = 1'b1; i.mop = 1'b1; end
         2: begin i.mop = 1'b1; end
         default: begin end
      endcase
      return i;
   endfunction

   vec_t tbl [$];

   initial begin
      rstn = 1'b0;
      set_in(nop(), 1'b0, 1'b1);

      // ---------- table-driven directed vectors ----------
`ifdef FORWARD_EN
      // add x5 ; add x6,x5,x1 -> no stall, consumer sees fwd_a=01
      tbl.push_back(row(alu(5'd5, 5'd1, 5'd2), e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(alu(5'd6, 5'd5, 5'd1), e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b01,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));
      // lw x7 ; add x8,x7,x7 -> one stall + bubble, then fwd 10/10
      tbl.push_back(row(lw(5'd7, 5'd1),        e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(alu(5'd8, 5'd7, 5'd7), e(1,0,1,0,2'b00,2'b00)));
      tbl.push_back(row(alu(5'd8, 5'd7, 5'd7), e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b10,2'b10)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));
`else
      // add x5 ; add x6,x5,x1 -> two stall cycles, fwd stays 00
      tbl.push_back(row(alu(5'd5, 5'd1, 5'd2), e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(alu(5'd6, 5'd5, 5'd1), e(1,0,1,0,2'b00,2'b00)));
      tbl.push_back(row(alu(5'd6, 5'd5, 5'd1), e(1,0,1,0,2'b00,2'b00)));
      tbl.push_back(row(alu(5'd6, 5'd5, 5'd1), e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));
      // lw x7 ; add x8,x7,x7 -> stalls while the load is in EX and MEM
      tbl.push_back(row(lw(5'd7, 5'd1),        e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(alu(5'd8, 5'd7, 5'd7), e(1,0,1,0,2'b00,2'b00)));
      tbl.push_back(row(alu(5'd8, 5'd7, 5'd7), e(1,0,1,0,2'b00,2'b00)));
      tbl.push_back(row(alu(5'd8, 5'd7, 5'd7), e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));
`endif
      // producer writes x0, consumer reads x0 -> no hazard, no forwarding
      tbl.push_back(row(alu(5'd0, 5'd1, 5'd2), e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(alu(5'd9, 5'd0, 5'd0), e(0,0,0,0,2'b00,2'b00)));
      tbl.push_back(row(nop(),                 e(0,0,0,0,2'b00,2'b00)));

      do_reset();
      foreach (tbl[i]) begin
         apply(tbl[i].ins, tbl[i].redir, tbl[i].mrdy);
         chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
         @(posedge clk);
      end
      apply(nop(), 1'b0, 1'b1);
      chk("table_stall_cycles", 32'(stall_cycles), FWD ? 32'd1 : 32'd4);

      // ---------- freeze for 3 cycles with a pending redirect ----------
      do_reset();
      apply(lw(5'd7, 5'd1), 1'b0, 1'b1);
      @(posedge clk);
      apply(nop(), 1'b0, 1'b1);
      chk("frz_pre", 32'(freeze), 32'd0);
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         apply(alu(5'd3, 5'd1, 5'd2), 1'b1, 1'b0);
         chk($sformatf("frz_hold%0d", c), 32'({stall_if, flush_id, bubble_ex, freeze}), 32'b0001);
         @(posedge clk);
      end
      apply(alu(5'd3, 5'd1, 5'd2), 1'b1, 1'b1);
      chk("frz_release_redirect", 32'({stall_if, flush_id, bubble_ex, freeze}), 32'b0110);
      @(posedge clk);
      apply(nop(), 1'b0, 1'b1);
      chk("frz_stall_cycles", 32'(stall_cycles), 32'd3);

      // ---------- load-use hazard and redirect in the same cycle ----------
      do_reset();
      apply(lw(5'd7, 5'd1), 1'b0, 1'b1);
      @(posedge clk);
      apply(alu(5'd8, 5'd7, 5'd7), 1'b1, 1'b1);
      chk("redir_over_stall", 32'({stall_if, flush_id, bubble_ex, freeze}), 32'b0110);
      @(posedge clk);
      apply(nop(), 1'b0, 1'b1);
      chk("redir_cnt", 32'(stall_cycles), 32'd0);
      chk("redir_fwd", 32'({fwd_a, fwd_b}), 32'd0);

      // ---------- reset pulsed during a freeze ----------
      do_reset();
      apply(lw(5'd7, 5'd1), 1'b0, 1'b1);
      @(posedge clk);
      apply(nop(), 1'b0, 1'b1);
      @(posedge clk);
      apply(nop(), 1'b0, 1'b0);
      chk("rst_frz_pre", 32'(freeze), 32'd1);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("rst_async_outs", 32'(outs()), 32'd0);
      chk("rst_async_cnt", 32'(stall_cycles), 32'd0);
      rstn = 1'b1;
      set_in(alu(5'd8, 5'd7, 5'd7), 1'b0, 1'b0);
      #1;
      chk("rst_after_outs", 32'(outs()), 32'd0);
      @(posedge clk);
      apply(nop(), 1'b0, 1'b0);
      chk("rst_after_fwd", 32'(outs()), 32'd0);

      // ---------- random stimulus against the model ----------
      do_reset();
      for (int n = 0; n < 400; n++) begin
         apply(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
         model_eval();
         chk("rnd_ctl", 32'({stall_if, flush_id, bubble_ex, freeze}),
             32'({e_stall, e_flush, e_bubble, e_freeze}));
         chk("rnd_fwd", 32'({fwd_a, fwd_b}), 32'({m_fa, m_fb}));
         chk("rnd_cnt", 32'(stall_cycles), 32'(m_cnt));
         chk("rnd_sat", 32'({s_stall_if, s_flush_id, s_bubble_ex, s_freeze, s_fwd_a, s_fwd_b, s_stall_cycles}),
             32'({e_stall, e_flush, e_bubble, e_freeze, m_fa, m_fb, 2'(m_cnt_s)}));
         @(posedge clk);
         model_step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
